// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the two-master arbiter: widths, burst default,
// FSM state encodings and the per-master request bundle.
package bus_arbiter_pkg;

  localparam int BUS_ADDR_W    = 8;
  localparam int BUS_DATA_W    = 32;
  localparam int BURST_MAX_DEF = 16;

  // Arbiter FSM encodings; the state register is one bit wide.
  localparam logic [0:0] ST_M0_GRANT = 1'b0;
  localparam logic [0:0] ST_M1_GRANT = 1'b1;

  // One master's view of the shared bus.
  typedef struct packed {
    logic                  req;
    logic                  wr;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] dout;
  } bus_req_t;

  // A read is active only when the bus is requested and not writing.
  function automatic logic is_read(input logic req, input logic wr);
    return req & ~wr;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle shared by both masters, the arbiter and the slave side.
//
// Handshake: a master holds req high for as long as it wants the bus and
// may drive wr/address/dout only while its grant is high. Grants are
// registered, so a master raising req sees its grant at the earliest on
// the following cycle; exactly one grant is high in every cycle. Read data
// on m_din belongs to the read that was on the bus one cycle earlier.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  // Master 0 (host) and master 1 (DMAC) requests.
  logic                  m0_req;
  logic                  m0_wr;
  logic [BUS_ADDR_W-1:0] m0_address;
  logic [BUS_DATA_W-1:0] m0_dout;
  logic                  m1_req;
  logic                  m1_wr;
  logic [BUS_ADDR_W-1:0] m1_address;
  logic [BUS_DATA_W-1:0] m1_dout;

  // Ownership and the muxed bus toward the decoder and slaves.
  logic                  m0_grant;
  logic                  m1_grant;
  logic                  m_req;
  logic                  m_wr;
  logic [BUS_ADDR_W-1:0] m_address;
  logic [BUS_DATA_W-1:0] m_dout;

  // Decoder selects, slave read data and steered return data.
  logic                  s0_sel;
  logic                  s1_sel;
  logic                  s2_sel;
  logic                  s3_sel;
  logic [BUS_DATA_W-1:0] s0_dout;
  logic [BUS_DATA_W-1:0] s1_dout;
  logic [BUS_DATA_W-1:0] s2_dout;
  logic [BUS_DATA_W-1:0] s3_dout;
  logic [BUS_DATA_W-1:0] m_din;

  // Current arbiter FSM state, for observation only.
  logic [0:0]            dbg_state;

  // The arbiter masters the shared bus: it drives grants, m_* and m_din.
  modport master (
    input  m0_req, m0_wr, m0_address, m0_dout,
    input  m1_req, m1_wr, m1_address, m1_dout,
    input  s0_sel, s1_sel, s2_sel, s3_sel,
    input  s0_dout, s1_dout, s2_dout, s3_dout,
    output m0_grant, m1_grant,
    output m_req, m_wr, m_address, m_dout,
    output m_din, dbg_state
  );

  // The surrounding system: requesting masters, decoder and slaves.
  modport slave (
    output m0_req, m0_wr, m0_address, m0_dout,
    output m1_req, m1_wr, m1_address, m1_dout,
    output s0_sel, s1_sel, s2_sel, s3_sel,
    output s0_dout, s1_dout, s2_dout, s3_dout,
    input  m0_grant, m1_grant,
    input  m_req, m_wr, m_address, m_dout,
    input  m_din, dbg_state
  );

endinterface

// File: rtl/bus_rd_mux.sv
// Read-data steering: registers which slave answered a bus read and
// returns that slave's data one cycle later.
module bus_rd_mux
  import bus_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_req_i,
  input  logic                  m_wr_i,
  input  logic [3:0]            sel_i,
  input  logic [BUS_DATA_W-1:0] s0_dout_i,
  input  logic [BUS_DATA_W-1:0] s1_dout_i,
  input  logic [BUS_DATA_W-1:0] s2_dout_i,
  input  logic [BUS_DATA_W-1:0] s3_dout_i,
  output logic [BUS_DATA_W-1:0] m_din_o
);

  logic [3:0] rsel_q;
  logic [3:0] rsel_d;

  // Only a live read leaves a slave selected for the data return.
  always_comb begin
    rsel_d = sel_i & {4{is_read(m_req_i, m_wr_i)}};
  end

  // Capture the read select every cycle; reset drops any pending return.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsel_q <= 4'b0000;
    end else begin
      rsel_q <= rsel_d;
    end
  end

  // Steer exactly one slave; zero or several selects return zero.
  always_comb begin
    m_din_o = '0;
    case (rsel_q)
      4'b0001: m_din_o = s0_dout_i;
      4'b0010: m_din_o = s1_dout_i;
      4'b0100: m_din_o = s2_dout_i;
      4'b1000: m_din_o = s3_dout_i;
      default: m_din_o = '0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter. Master 0 (host) owns the bus by default; master 1
// (DMAC) gets it when M0 is idle and keeps it for at most BURST_MAX cycles
// of M0 waiting. Also muxes the owner's signals onto the shared bus and
// returns slave read data through bus_rd_mux.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bus
);

  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] burst_d;

  bus_req_t m0_bus;
  bus_req_t m1_bus;
  bus_req_t own_bus;

  assign m0_bus = '{req: bus.m0_req, wr: bus.m0_wr,
                    addr: bus.m0_address, dout: bus.m0_dout};
  assign m1_bus = '{req: bus.m1_req, wr: bus.m1_wr,
                    addr: bus.m1_address, dout: bus.m1_dout};

  // Next-state: M0 wins ties; M1 yields when done or its burst is used up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_M0_GRANT: begin
        if (!bus.m0_req && bus.m1_req) begin
          state_d = ST_M1_GRANT;
        end
      end
      ST_M1_GRANT: begin
        if (!bus.m1_req) begin
          state_d = ST_M0_GRANT;
        end else if (bus.m0_req && (burst_q == CNT_LAST)) begin
          state_d = ST_M0_GRANT;
        end
      end
      default: state_d = ST_M0_GRANT;
    endcase
  end

  // Burst counter: counts M1 cycles during which M0 is waiting, holds while
  // M0 is idle, saturates, and restarts from zero on every new M1 tenure.
  always_comb begin
    burst_d = burst_q;
    if (state_q == ST_M0_GRANT || state_d == ST_M0_GRANT) begin
      burst_d = '0;
    end else if (bus.m0_req && (burst_q != CNT_LAST)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  // State and counter registers; reset returns ownership to M0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_M0_GRANT;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Moore grants and the owner's signals on the shared bus.
  always_comb begin
    own_bus = (state_q == ST_M1_GRANT) ? m1_bus : m0_bus;
  end

  assign bus.m0_grant  = (state_q == ST_M0_GRANT);
  assign bus.m1_grant  = (state_q == ST_M1_GRANT);
  assign bus.m_req     = own_bus.req;
  assign bus.m_wr      = own_bus.req & own_bus.wr;
  assign bus.m_address = own_bus.addr;
  assign bus.m_dout    = own_bus.dout;
  assign bus.dbg_state = state_q;

  bus_rd_mux u_rd_mux (
    .clk       (clk),
    .reset     (reset),
    .m_req_i   (bus.m_req),
    .m_wr_i    (bus.m_wr),
    .sel_i     ({bus.s3_sel, bus.s2_sel, bus.s1_sel, bus.s0_sel}),
    .s0_dout_i (bus.s0_dout),
    .s1_dout_i (bus.s1_dout),
    .s2_dout_i (bus.s2_dout),
    .s3_dout_i (bus.s3_dout),
    .m_din_o   (bus.m_din)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for burst limiting and reset during M1 reads.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam logic [31:0] M0D = 32'h1111_0000;
  localparam logic [31:0] M1D = 32'h2222_0000;
  localparam logic [31:0] S0D = 32'h0000_0A00;
  localparam logic [31:0] S1D = 32'hDEAD_BEEF;
  localparam logic [31:0] S2D = 32'hC0FF_EE02;
  localparam logic [31:0] S3D = 32'h3333_3333;
  localparam int          NV  = 14;

  typedef struct {
    logic        rst;
    logic        m0_req;
    logic        m0_wr;
    logic [7:0]  m0_addr;
    logic        m1_req;
    logic        m1_wr;
    logic [7:0]  m1_addr;
    logic [3:0]  sel;
    logic        e_g0;
    logic        e_g1;
    logic        e_req;
    logic        e_wr;
    logic [7:0]  e_addr;
    logic [31:0] e_dout;
    logic [31:0] e_din;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] exp_q[$];
  vec_t vecs[NV];

  bus_arbiter_if bus ();

  bus_arbiter #(.BURST_MAX(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one table row onto the bus inputs.
  task automatic drive(input vec_t v);
    reset          = v.rst;
    bus.m0_req     = v.m0_req;
    bus.m0_wr      = v.m0_wr;
    bus.m0_address = v.m0_addr;
    bus.m1_req     = v.m1_req;
    bus.m1_wr      = v.m1_wr;
    bus.m1_address = v.m1_addr;
    {bus.s3_sel, bus.s2_sel, bus.s1_sel, bus.s0_sel} = v.sel;
  endtask

  // Put M1 in charge of the bus from an M0-owned, idle state.
  task automatic enter_m1();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b1;
    bus.m1_wr  = 1'b1;
    {bus.s3_sel, bus.s2_sel, bus.s1_sel, bus.s0_sel} = 4'b0000;
    tick();
    check("enter_m1_grant", {31'd0, bus.m1_grant}, 32'd1);
  endtask

  // Count cycles M1 keeps the bus after M0 starts requesting (bounded).
  task automatic count_m1(input string name, input int exp_cycles);
    int n;
    n = 1;
    bus.m0_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.m1_grant) n++;
      else break;
    end
    check(name, n, exp_cycles);
    check({name, "_m0_grant"}, {31'd0, bus.m0_grant}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.m0_req = 0; bus.m0_wr = 0; bus.m0_address = 0; bus.m0_dout = M0D;
    bus.m1_req = 0; bus.m1_wr = 0; bus.m1_address = 0; bus.m1_dout = M1D;
    bus.s0_sel = 0; bus.s1_sel = 0; bus.s2_sel = 0; bus.s3_sel = 0;
    bus.s0_dout = S0D; bus.s1_dout = S1D; bus.s2_dout = S2D; bus.s3_dout = S3D;

    // rst m0:req wr addr  m1:req wr addr  sel  | g0 g1 req wr addr dout din
    vecs[0]  = '{1, 0, 1, 8'h05, 0, 0, 8'h00, 4'b0000, 1, 0, 0, 0, 8'h05, M0D, 32'h0};
    vecs[1]  = '{0, 1, 1, 8'h12, 1, 0, 8'h33, 4'b0010, 1, 0, 1, 1, 8'h12, M0D, 32'h0};
    vecs[2]  = '{0, 1, 1, 8'h12, 1, 0, 8'h33, 4'b0010, 1, 0, 1, 1, 8'h12, M0D, 32'h0};
    vecs[3]  = '{0, 1, 1, 8'h12, 1, 0, 8'h33, 4'b0010, 1, 0, 1, 1, 8'h12, M0D, 32'h0};
    vecs[4]  = '{0, 1, 1, 8'h12, 1, 0, 8'h33, 4'b0010, 1, 0, 1, 1, 8'h12, M0D, 32'h0};
    vecs[5]  = '{0, 1, 1, 8'h12, 1, 0, 8'h33, 4'b0010, 1, 0, 1, 1, 8'h12, M0D, 32'h0};
    vecs[6]  = '{0, 0, 0, 8'h12, 1, 0, 8'h21, 4'b0000, 0, 1, 1, 0, 8'h21, M1D, 32'h0};
    vecs[7]  = '{0, 0, 0, 8'h12, 1, 0, 8'h21, 4'b0100, 0, 1, 1, 0, 8'h21, M1D, S2D};
    vecs[8]  = '{0, 0, 0, 8'h40, 0, 0, 8'h21, 4'b0000, 1, 0, 0, 0, 8'h40, M0D, 32'h0};
    vecs[9]  = '{0, 1, 0, 8'h10, 0, 0, 8'h21, 4'b0010, 1, 0, 1, 0, 8'h10, M0D, S1D};
    vecs[10] = '{0, 1, 1, 8'h10, 0, 0, 8'h21, 4'b0010, 1, 0, 1, 1, 8'h10, M0D, 32'h0};
    vecs[11] = '{0, 1, 0, 8'h70, 0, 0, 8'h21, 4'b0000, 1, 0, 1, 0, 8'h70, M0D, 32'h0};
    vecs[12] = '{0, 1, 0, 8'h50, 0, 0, 8'h21, 4'b0011, 1, 0, 1, 0, 8'h50, M0D, 32'h0};
    vecs[13] = '{0, 1, 0, 8'h60, 0, 0, 8'h21, 4'b1000, 1, 0, 1, 0, 8'h60, M0D, S3D};

    // Table: inputs held across one rising edge, outputs sampled after it.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i].e_din);
      tick();
      check($sformatf("v%0d_m0_grant", i), {31'd0, bus.m0_grant}, {31'd0, vecs[i].e_g0});
      check($sformatf("v%0d_m1_grant", i), {31'd0, bus.m1_grant}, {31'd0, vecs[i].e_g1});
      check($sformatf("v%0d_m_req", i), {31'd0, bus.m_req}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d_m_wr", i), {31'd0, bus.m_wr}, {31'd0, vecs[i].e_wr});
      check($sformatf("v%0d_m_address", i), {24'd0, bus.m_address}, {24'd0, vecs[i].e_addr});
      check($sformatf("v%0d_m_dout", i), bus.m_dout, vecs[i].e_dout);
      check($sformatf("v%0d_m_din", i), bus.m_din, exp_q.pop_front());
    end

    // Full burst: M0 waits while M1 holds; M1 keeps the bus 16 cycles.
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
    enter_m1();
    count_m1("burst_full", 16);

    // Counter holds while M0 stops requesting: 5 + 11 = 16 waiting cycles.
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
    enter_m1();
    bus.m0_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.m0_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("burst_hold_still_m1", {31'd0, bus.m1_grant}, 32'd1);
    count_m1("burst_resume", 11);

    // Reset during an M1 read: grant back to M0, pending read dropped.
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
    enter_m1();
    bus.m1_wr = 1'b0;
    bus.s0_sel = 1'b1;
    exp_q.push_back(S0D);
    tick();
    check("m1_read_din", bus.m_din, exp_q.pop_front());
    reset = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    check("rst_mid_m0_grant", {31'd0, bus.m0_grant}, 32'd1);
    check("rst_mid_m1_grant", {31'd0, bus.m1_grant}, 32'd0);
    check("rst_mid_m_din", bus.m_din, exp_q.pop_front());
    check("rst_mid_state", {31'd0, bus.dbg_state}, {31'd0, ST_M0_GRANT});
    reset = 1'b0;
    bus.m1_req = 1'b0; bus.s0_sel = 1'b0;
    tick();

    // Final report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 16, max consecutive M1 ownership cycles while M0 is requesting.
REQ-002 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, reset that is synchronous and active-high.
REQ-004 Ports m0_req, m0_wr, input, 1 each, master 0 (host) request and write strobe.
REQ-005 Ports m0_address, input, 8; m0_dout, input, 32; master 0 address and write data.
REQ-006 Ports m1_req, m1_wr, m1_address[7:0], m1_dout[31:0], inputs, master 1 (DMAC), same meanings.
REQ-007 Ports m0_grant, m1_grant, output, 1 each, bus ownership.
REQ-008 Ports m_req, m_wr, output, 1; m_address, output, 8; m_dout, output, 32; the granted master's signals, driven to the address decoder and slaves.
REQ-009 Ports s0_sel..s3_sel, input, 1 each, one-hot slave selects from the address decoder.
REQ-010 Ports s0_dout..s3_dout, input, 32 each, slave read data.
REQ-011 Port m_din, output, 32, steered read data returned to both masters.

Function
REQ-012 FSM states: M0_GRANT, M1_GRANT; grants are Moore outputs (m0_grant=1 only in M0_GRANT, m1_grant=1 only in M1_GRANT), so exactly one grant is high every cycle.
REQ-013 M0_GRANT: stay if m0_req=1 or m1_req=0; go to M1_GRANT if m0_req=0 and m1_req=1.
REQ-014 M1_GRANT: go to M0_GRANT if m1_req=0; go to M0_GRANT if m0_req=1 and burst count equals BURST_MAX-1; otherwise stay.
REQ-015 Burst counter: cleared on entering M1_GRANT and while in M0_GRANT; increments each cycle in M1_GRANT with m0_req=1; holds when m0_req=0; saturates, never wraps.
REQ-016 Simultaneous m0_req=1 and m1_req=1 in M0_GRANT: M0 keeps the bus.
REQ-017 Grant changes take effect one cycle after the deciding request edge; a newly requesting master sees its grant no earlier than the next cycle.
REQ-018 m_req/m_wr/m_address/m_dout are a combinational mux of the granted master's inputs; m_wr forced 0 whenever m_req=0.
REQ-019 Read-select register rsel[3:0] captures {s3_sel,s2_sel,s1_sel,s0_sel} AND m_req AND NOT m_wr each cycle; read data therefore has one cycle latency.
REQ-020 m_din = sN_dout for the single set bit of rsel; 32'h0 when rsel is zero or not one-hot.

Reset
REQ-021 With reset=1 at a rising edge: state M0_GRANT, burst counter 0, rsel 0.
REQ-022 Outputs after reset: m0_grant=1, m1_grant=0, m_din=0, m_req/m_wr/m_address/m_dout reflect M0 inputs, m_wr=0 when m0_req=0.
REQ-023 Reset asserted mid-M1 transfer: ownership returns to M0 at that edge; no pending read data is delivered.

Structure
REQ-024 Shared bus package holds state encodings, BUS_ADDR_W=8, BUS_DATA_W=32, BURST_MAX default.
REQ-025 Read-data steering (rsel register plus mux) is a sub-module named bus_rd_mux; FSM, counter and master mux remain in bus_arbiter.

Verification
REQ-026 Reset, then m0_req=1, m1_req=1 for 5 cycles -> m0_grant=1 throughout, m_address=m0_address.
REQ-027 m0_req=0, m1_req=1, m1_address=8'h21 -> m1_grant=1 next cycle, m_address=8'h21; drop m1_req -> m0_grant=1 next cycle.
REQ-028 In M1_GRANT, m0_req=1 held, m1_req=1 held -> m1_grant high exactly 16 cycles after m0_req rises, then m0_grant=1.
REQ-029 M0 read at 8'h10 (s1_sel=1, s1_dout=32'hDEADBEEF) -> m_din=32'hDEADBEEF one cycle later; write at 8'h10 -> m_din=0 next cycle.
REQ-030 Address 8'h70 read (no select) -> m_din=0; reset asserted during M1 read -> m0_grant=1, m_din=0 after that edge.
